fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter,
//  drives the combinational imem read address, and buffers fetched {pc, instr} pairs in a small
//  in-order queue. Decode drains the queue with a valid/ready handshake. Redirects (branch/jump)
//  from execute flush the queue and restart fetch at the target.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  DEPTH     2              queue entries (power of 2, >=2)
//  NOP       32'h0000_0013  instr driven on dec_instr_o while queue empty (addi x0,x0,0)
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  imem_addr_o   out  32  byte address to imem (always word aligned)
//  imem_rd_i     in   32  instruction word from imem, combinational on imem_addr_o
//  redirect_i    in   1   1 = load redirect_pc_i into PC this edge
//  redirect_pc_i in   32  redirect target byte address
//  dec_valid_o   out  1   queue head valid
//  dec_ready_i   in   1   decode accepts head this edge
//  dec_pc_o      out  32  PC of head entry
//  dec_instr_o   out  32  instruction of head entry
//  imisalign_o   out  1   1-cycle pulse: redirect target had [1:0]!=0
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, queue empty (count=0), dec_valid_o=0, dec_pc_o=0,
//   dec_instr_o=NOP, imisalign_o=0. Outputs take these values immediately, independent of clk.
//  imem_addr_o = pc (combinational from the PC register).
//  push = !redirect_i && (count<DEPTH || (dec_valid_o && dec_ready_i)).
//  pop  = dec_valid_o && dec_ready_i.
//  Each rising edge, in priority order:
//   1 redirect_i=1: pc <= {redirect_pc_i[31:2],2'b00}; queue cleared (count=0); no push and no pop
//     take effect; imisalign_o <= |redirect_pc_i[1:0] (else 0).
//   2 otherwise: on push, write {pc, imem_rd_i} at tail and pc <= pc+4 (mod 2^32: FFFF_FFFC -> 0);
//     on pop, advance head; push and pop in the same edge are both legal, including when full.
//     If no push, pc holds. imisalign_o <= 0.
//  count updates +1 push-only, -1 pop-only, unchanged when both or neither; never exceeds DEPTH.
//  dec_valid_o = (count!=0); dec_pc_o/dec_instr_o = head entry, NOP/0 when empty (registered
//   storage, muxed combinationally by head pointer).
//  Latency: instruction at PC X fetched in cycle N is dec_valid_o in cycle N+1. After a redirect edge
//   at end of cycle N, the target is fetched in cycle N+1 and presented in cycle N+2.
//  Entries are delivered strictly in fetch order; no entry is lost or duplicated under backpressure.
//  An entry present on the head in the same cycle as redirect_i is discarded even if dec_ready_i=1.
//  Head/tail pointers wrap modulo DEPTH.
// TESTING
//  1 Release reset, dec_ready_i=1, imem loaded with program -> first dec_valid_o one cycle after the
//    first edge; dec_pc_o/dec_instr_o = 0/00500113, 4/00c00193, 8/ff718393 on consecutive cycles.
//  2 dec_ready_i=0 for 5 cycles from reset -> count saturates at 2, imem_addr_o holds 0x8;
//    raise ready -> pc 0,4,8,C delivered back-to-back, no gap or duplicate.
//  3 Queue full, dec_ready_i=1, redirect_i=1 to 0x40 -> head in that cycle not counted as accepted;
//    next cycle dec_valid_o=0; following cycle dec_pc_o=0x40, dec_instr_o=008001ef.
//  4 redirect_pc_i=0x42 -> imisalign_o=1 for exactly one cycle; imem_addr_o=0x40 next cycle.
//  5 rst_n pulled low mid-stream (between edges, queue non-empty) -> dec_valid_o=0,
//    dec_instr_o=NOP, imem_addr_o=RESET_PC immediately, before next edge.
//  6 RESET_PC=32'hFFFF_FFF8, ready=1 -> dec_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem address and buffers
// fetched {pc, instr} pairs in an in-order queue drained by decode.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_instr_o,
  output logic        imisalign_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  // A full queue can still accept a new fetch when decode drains the head in the same edge.
  always_comb begin
    dec_valid_o = (count != '0);
    pop         = dec_valid_o && dec_ready_i;
    push        = !redirect_i && ((count != FULL) || pop);
    imem_addr_o = pc;
    dec_pc_o    = dec_valid_o ? pc_q[head] : 32'h0;
    dec_instr_o = dec_valid_o ? instr_q[head] : NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      imisalign_o <= 1'b0;
    end else if (redirect_i) begin
      pc          <= {redirect_pc_i[31:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      imisalign_o <= |redirect_pc_i[1:0];
    end else begin
      imisalign_o <= 1'b0;
      if (push) begin
        pc   <= pc + 32'd4;
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW+1)'(1);
      end
    end
  end

  // Payload storage needs no reset: the empty-queue mux hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]    <= pc;
      instr_q[tail] <= imem_rd_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        imisalign;

  logic        rst_hi_n;
  logic [31:0] hi_addr;
  logic [31:0] hi_rd;
  logic        hi_valid;
  logic [31:0] hi_pc;
  logic [31:0] hi_instr;
  logic        hi_mis;
  logic        hi_redirect = 1'b0;
  logic [31:0] hi_redirect_pc = 32'h0;
  logic        hi_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [32];
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic        m_mis;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd128) return prog[a[6:2]];
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rd = mem_word(imem_addr);
  assign hi_rd   = mem_word(hi_addr);

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr_o(imem_addr), .imem_rd_i(imem_rd),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .dec_valid_o(dec_valid),
    .dec_ready_i(ready), .dec_pc_o(dec_pc), .dec_instr_o(dec_instr), .imisalign_o(imisalign)
  );

  fetch_unit #(.RESET_PC(HI_PC), .DEPTH(DEPTH), .NOP(NOP)) dut_hi (
    .clk(clk), .rst_n(rst_hi_n), .imem_addr_o(hi_addr), .imem_rd_i(hi_rd),
    .redirect_i(hi_redirect), .redirect_pc_i(hi_redirect_pc), .dec_valid_o(hi_valid),
    .dec_ready_i(hi_ready), .dec_pc_o(hi_pc), .dec_instr_o(hi_instr), .imisalign_o(hi_mis)
  );

  // Reference model: a plain queue of fetched pairs plus the next fetch address.
  function automatic void model_reset(input logic [31:0] rpc);
    m_q.delete();
    m_pc  = rpc;
    m_mis = 1'b0;
  endfunction

  function automatic void model_edge();
    bit          do_pop;
    bit          do_push;
    logic [63:0] entry;
    if (redirect) begin
      m_q.delete();
      m_pc  = {redirect_pc[31:2], 2'b00};
      m_mis = |redirect_pc[1:0];
    end else begin
      do_pop  = (m_q.size() != 0) && ready;
      do_push = (m_q.size() < DEPTH) || do_pop;
      entry   = {m_pc, mem_word(m_pc)};
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(entry);
        m_pc = m_pc + 32'd4;
      end
      m_mis = 1'b0;
    end
  endfunction

  function automatic logic [97:0] exp_vec();
    logic v;
    v = (m_q.size() != 0);
    return {v, v ? m_q[0][63:32] : 32'h0, v ? m_q[0][31:0] : NOP, m_pc, m_mis};
  endfunction

  function automatic logic [97:0] act_vec();
    return {dec_valid, dec_pc, dec_instr, imem_addr, imisalign};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect = 1'b0;
    model_reset(32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset(32'h0);
    #1;
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    logic [31:0] want [3];
    want = '{32'h0050_0113, 32'h00c0_0193, 32'hff71_8393};
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL basic_fetch_%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (i < 3) begin
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'(i * 4) || dec_instr !== want[i]) begin
          errors++;
          $display("[TB] FAIL basic_head_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                   i, dec_valid, dec_pc, dec_instr, 32'(i * 4), want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    repeat (5) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL stall_cycle: got %h expected %h", act_vec(), exp_vec());
      end
    end
    checks++;
    if (imem_addr !== 32'h8 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL stall_saturate: got addr=%h v=%b pc=%h expected addr=8 v=1 pc=0",
               imem_addr, dec_valid, dec_pc);
    end
    ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec() || dec_pc !== 32'(i * 4) || dec_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain_%0d: got %h expected %h (pc %h)", i, act_vec(), exp_vec(), 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    ready = 1'b0;
    repeat (3) step();
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    checks++;
    if (act_vec() !== exp_vec() || dec_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect_flush: got %h expected %h", act_vec(), exp_vec());
    end
    redirect = 1'b0;
    step();
    checks++;
    if (act_vec() !== exp_vec() || dec_pc !== 32'h40 || dec_instr !== 32'h0080_01ef) begin
      errors++;
      $display("[TB] FAIL redirect_target: got pc=%h instr=%h expected pc=00000040 instr=008001ef",
               dec_pc, dec_instr);
    end
  endtask

  task automatic test_misaligned();
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h42;
    step();
    checks++;
    if (act_vec() !== exp_vec() || imisalign !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL misalign_pulse: got mis=%b addr=%h expected mis=1 addr=00000040",
               imisalign, imem_addr);
    end
    redirect = 1'b0;
    step();
    checks++;
    if (act_vec() !== exp_vec() || imisalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misalign_clear: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset(32'h0);
    #1;
    checks++;
    if (act_vec() !== exp_vec() || dec_valid !== 1'b0 || dec_instr !== NOP || imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 127)) : $urandom;
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] want_pc [3];
    want_pc = '{HI_PC, 32'hFFFF_FFFC, 32'h0000_0000};
    @(negedge clk);
    checks++;
    if (hi_addr !== HI_PC || hi_valid !== 1'b0 || hi_instr !== NOP) begin
      errors++;
      $display("[TB] FAIL wrap_reset: got addr=%h v=%b expected addr=%h v=0", hi_addr, hi_valid, HI_PC);
    end
    rst_hi_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (hi_valid !== 1'b1 || hi_pc !== want_pc[i] || hi_instr !== mem_word(want_pc[i])) begin
        errors++;
        $display("[TB] FAIL wrap_seq_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, hi_valid, hi_pc, hi_instr, want_pc[i], mem_word(want_pc[i]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rst_hi_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    ready = 1'b0;
    for (int i = 0; i < 32; i++) prog[i] = 32'h0000_0013 | (32'(i) << 20);
    prog[0]  = 32'h0050_0113;
    prog[1]  = 32'h00c0_0193;
    prog[2]  = 32'hff71_8393;
    prog[3]  = 32'h0023_e233;
    prog[16] = 32'h0080_01ef;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_async_reset();
    test_random();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
